// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command controller: opcodes, FSM encoding and
// response flag bit positions.
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_NOT  = 4'd5;
   localparam logic [3:0] OP_SHL  = 4'd6;
   localparam logic [3:0] OP_SHR  = 4'd7;
   localparam logic [3:0] OP_SLT  = 4'd8;
   localparam logic [3:0] OP_LAST = 4'd8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam int FLAG_V = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_Z = 0;

   function automatic logic op_legal(input logic [3:0] op);
      return op <= OP_LAST;
   endfunction

endpackage

// File: rtl/alu_cmd_regfile.sv
// Small register file: two asynchronous read ports, one synchronous write port,
// asynchronous clear of every entry.
module alu_cmd_regfile #(
   parameter int AW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr_a,
   input  logic [AW-1:0] raddr_b,
   output logic [7:0]    rdata_a,
   output logic [7:0]    rdata_b
);

   logic [7:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < (1<<AW); i++) mem[i] <= 8'h00;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata_a = mem[raddr_a];
   assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Command controller for the external combinational 8-bit ALU: reads operands,
// registers the ALU inputs, captures result/flags, writes back and responds.
module alu_cmd_ctrl
   import alu_pkg::*;
#(
   parameter int REG_AW = 2
) (
   input  logic              clk,
   input  logic              rst,
   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; valid holds its payload stable until that edge.
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd_op,
   input  logic [REG_AW-1:0] cmd_rd,
   input  logic [REG_AW-1:0] cmd_rs1,
   input  logic [REG_AW-1:0] cmd_rs2,
   input  logic              cmd_imm_en,
   input  logic [7:0]        cmd_imm,
   output logic [7:0]        alu_a,
   output logic [7:0]        alu_b,
   output logic [3:0]        alu_opcode,
   input  logic [7:0]        alu_result,
   input  logic              alu_overflow,
   input  logic              alu_negative,
   input  logic              alu_zero,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [7:0]        rsp_data,
   output logic [2:0]        rsp_flags,
   output logic              rsp_err,
   output logic [1:0]        state_dbg
);

   state_t            state, state_next;
   logic [REG_AW-1:0] rd_q;
   logic [7:0]        rf_a, rf_b;
   logic              accept;
   logic              wb_en;

   assign cmd_ready = (state == ST_IDLE) & ~rst;
   assign rsp_valid = (state == ST_RESP);
   assign accept    = cmd_valid & cmd_ready;
   assign wb_en     = (state == ST_EXEC) & op_legal(alu_opcode);
   assign state_dbg = state;

   alu_cmd_regfile #(.AW(REG_AW)) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .we      (wb_en),
      .waddr   (rd_q),
      .wdata   (alu_result),
      .raddr_a (cmd_rs1),
      .raddr_b (cmd_rs2),
      .rdata_a (rf_a),
      .rdata_b (rf_b)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (accept)    state_next = ST_EXEC;
         ST_EXEC:                state_next = ST_RESP;
         ST_RESP: if (rsp_ready) state_next = ST_IDLE;
         default:                state_next = ST_IDLE;
      endcase
   end

   // Operand capture; the ALU sees these registers for the whole EXEC cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_a      <= 8'h00;
         alu_b      <= 8'h00;
         alu_opcode <= 4'h0;
         rd_q       <= '0;
      end else if (accept) begin
         alu_a      <= rf_a;
         alu_b      <= cmd_imm_en ? cmd_imm : rf_b;
         alu_opcode <= cmd_op;
         rd_q       <= cmd_rd;
      end
   end

   // Illegal opcodes report an error with zeroed payload and skip writeback.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_data  <= 8'h00;
         rsp_flags <= 3'b000;
         rsp_err   <= 1'b0;
      end else if (state == ST_EXEC) begin
         if (op_legal(alu_opcode)) begin
            rsp_data          <= alu_result;
            rsp_flags[FLAG_V] <= alu_overflow;
            rsp_flags[FLAG_N] <= alu_negative;
            rsp_flags[FLAG_Z] <= alu_zero;
            rsp_err           <= 1'b0;
         end else begin
            rsp_data  <= 8'h00;
            rsp_flags <= 3'b000;
            rsp_err   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Bench for alu_cmd_ctrl: bit-level ALU stand-in, integer reference model of the
// register file and ALU, directed scenarios plus randomized commands.
module tb_alu_cmd_ctrl;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [1:0] cmd_rd;
  logic [1:0] cmd_rs1;
  logic [1:0] cmd_rs2;
  logic       cmd_imm_en;
  logic [7:0] cmd_imm;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_opcode;
  logic [7:0] alu_result;
  logic       alu_overflow;
  logic       alu_negative;
  logic       alu_zero;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [2:0] rsp_flags;
  logic       rsp_err;
  logic [1:0] state_dbg;

  int total = 0;
  int bad   = 0;

  // expected response: {err, v, n, z, data}
  logic [11:0] exp_q[$];
  int          model_regs[4];

  alu_cmd_ctrl #(.REG_AW(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_rd       (cmd_rd),
    .cmd_rs1      (cmd_rs1),
    .cmd_rs2      (cmd_rs2),
    .cmd_imm_en   (cmd_imm_en),
    .cmd_imm      (cmd_imm),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_opcode   (alu_opcode),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .alu_negative (alu_negative),
    .alu_zero     (alu_zero),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_flags    (rsp_flags),
    .rsp_err      (rsp_err),
    .state_dbg    (state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // combinational ALU stand-in, bit-level formulation
  always_comb begin
    alu_result   = 8'h00;
    alu_overflow = 1'b0;
    case (alu_opcode)
      4'd0: begin
        alu_result   = alu_a + alu_b;
        alu_overflow = (alu_a[7] == alu_b[7]) && (alu_result[7] != alu_a[7]);
      end
      4'd1: begin
        alu_result   = alu_a - alu_b;
        alu_overflow = (alu_a[7] != alu_b[7]) && (alu_result[7] != alu_a[7]);
      end
      4'd2: alu_result = alu_a & alu_b;
      4'd3: alu_result = alu_a | alu_b;
      4'd4: alu_result = alu_a ^ alu_b;
      4'd5: alu_result = ~alu_a;
      4'd6: alu_result = alu_a << alu_b[2:0];
      4'd7: alu_result = alu_a >> alu_b[2:0];
      4'd8: alu_result = {7'd0, ($signed(alu_a) < $signed(alu_b))};
      default: alu_result = 8'h00;
    endcase
    alu_negative = alu_result[7];
    alu_zero     = (alu_result == 8'h00);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int s8(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  // integer reference: compute the outcome of one command, queue it, update regs
  task automatic model_apply(input int op, input int rd, input int rs1, input int rs2,
                             input int imm_en, input int imm);
    int a, b, res, v, sr;
    logic [7:0] r8;
    a = model_regs[rs1];
    b = (imm_en != 0) ? imm : model_regs[rs2];
    res = 0;
    v = 0;
    case (op)
      0: begin sr = s8(a) + s8(b); v = (sr > 127 || sr < -128) ? 1 : 0; res = (a + b) % 256; end
      1: begin sr = s8(a) - s8(b); v = (sr > 127 || sr < -128) ? 1 : 0; res = (a - b + 256) % 256; end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = 255 - a;
      6: res = (a * (1 << (b % 8))) % 256;
      7: res = a / (1 << (b % 8));
      8: res = (s8(a) < s8(b)) ? 1 : 0;
      default: res = 0;
    endcase
    r8 = res[7:0];
    if (op <= 8) begin
      exp_q.push_back({1'b0, v[0], (res >= 128), (res == 0), r8});
      model_regs[rd] = res;
    end else begin
      exp_q.push_back({1'b1, 3'b000, 8'h00});
    end
  endtask

  task automatic check_rsp(input string tag);
    logic [11:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_data"}, rsp_data, e[7:0]);
      check({tag, "_flags"}, rsp_flags, e[10:8]);
      check({tag, "_err"}, rsp_err, e[11]);
    end
  endtask

  task automatic drive_cmd(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                           input logic [1:0] rs2, input logic ie, input logic [7:0] imm);
    cmd_op     = op;
    cmd_rd     = rd;
    cmd_rs1    = rs1;
    cmd_rs2    = rs2;
    cmd_imm_en = ie;
    cmd_imm    = imm;
    cmd_valid  = 1'b1;
  endtask

  // one full command with optional response backpressure of 'stall' cycles
  task automatic run_op(input string tag, input logic [3:0] op, input logic [1:0] rd,
                        input logic [1:0] rs1, input logic [1:0] rs2, input logic ie,
                        input logic [7:0] imm, input int stall);
    logic [7:0]  ea, eb;
    logic [11:0] e;
    int          t;
    @(negedge clk);
    check({tag, "_idle_rdy"}, cmd_ready, 1);
    drive_cmd(op, rd, rs1, rs2, ie, imm);
    t  = model_regs[rs1];
    ea = t[7:0];
    t  = ie ? int'(imm) : model_regs[rs2];
    eb = t[7:0];
    model_apply(op, rd, rs1, rs2, ie, imm);
    e = exp_q[exp_q.size()-1];
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check({tag, "_alu_a"}, alu_a, ea);
    check({tag, "_alu_b"}, alu_b, eb);
    check({tag, "_alu_op"}, alu_opcode, op);
    check({tag, "_exec_nvalid"}, rsp_valid, 0);
    check({tag, "_exec_nrdy"}, cmd_ready, 0);
    @(posedge clk); #1;
    check({tag, "_rsp_valid"}, rsp_valid, 1);
    check_rsp(tag);
    if (stall > 0) begin
      drive_cmd(4'd4, 2'd3, 2'd0, 2'd1, 1'b1, 8'hA5);
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        check({tag, "_hold_valid"}, rsp_valid, 1);
        check({tag, "_hold_data"}, rsp_data, e[7:0]);
        check({tag, "_hold_flags"}, rsp_flags, e[10:8]);
        check({tag, "_hold_nrdy"}, cmd_ready, 0);
        check({tag, "_hold_op"}, alu_opcode, op);
      end
      cmd_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, "_done_nvalid"}, rsp_valid, 0);
    check({tag, "_done_rdy"}, cmd_ready, 1);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) model_regs[i] = 0;
    exp_q.delete();
  endtask

  initial begin
    int acc_c[$];
    int n_rsp;

    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = 4'd0;
    cmd_rd     = 2'd0;
    cmd_rs1    = 2'd0;
    cmd_rs2    = 2'd0;
    cmd_imm_en = 1'b0;
    cmd_imm    = 8'h00;
    rsp_ready  = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_flags", rsp_flags, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_opcode, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_cmd_ready", cmd_ready, 1);

    // load, overflow, zero and subtract-overflow
    run_op("add_7f",  4'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h7F, 0);
    check("add_7f_lit", {20'd0, exp_q.size() == 0, 3'b000, 8'h7F}, {20'd1, 3'b000, 8'h7F});
    run_op("add_ovf", 4'd0, 2'd2, 2'd1, 2'd0, 1'b1, 8'h01, 0);
    run_op("sub_z",   4'd1, 2'd3, 2'd2, 2'd2, 1'b0, 8'h00, 0);
    run_op("sub_ovf", 4'd1, 2'd3, 2'd2, 2'd0, 1'b1, 8'h01, 0);
    check("r2_model", model_regs[2], 32'h80);

    // illegal opcode leaves r1 untouched
    run_op("illegal", 4'hA, 2'd1, 2'd0, 2'd0, 1'b1, 8'h12, 0);
    run_op("rd_r1",   4'd0, 2'd0, 2'd1, 2'd0, 1'b1, 8'h00, 0);

    // backpressure for five cycles
    run_op("bp", 4'd2, 2'd2, 2'd1, 2'd0, 1'b1, 8'h3C, 5);

    // reset while in EXEC aborts without writeback
    run_op("pre_rst", 4'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h33, 0);
    @(negedge clk);
    drive_cmd(4'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h55);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("rstx_state_exec", state_dbg, 1);
    rst = 1'b1;
    #1;
    check("rstx_rsp_valid", rsp_valid, 0);
    check("rstx_cmd_ready", cmd_ready, 0);
    check("rstx_alu_a", alu_a, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run_op("post_rst", 4'd0, 2'd0, 2'd1, 2'd0, 1'b1, 8'h00, 0);

    // back-to-back with cmd_valid and rsp_ready held high
    n_rsp = 0;
    @(negedge clk);
    drive_cmd(4'd0, 2'd1, 2'd1, 2'd0, 1'b1, 8'h01);
    rsp_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (c > 0) @(negedge clk);
      if (rsp_valid) begin
        check_rsp("b2b");
        n_rsp++;
      end
      if (cmd_valid && cmd_ready) begin
        acc_c.push_back(c);
        model_apply(0, 1, 1, 0, 1, 1);
        if (acc_c.size() == 3) begin
          @(posedge clk); #1;
          cmd_valid = 1'b0;
        end
      end
    end
    rsp_ready = 1'b0;
    check("b2b_n_acc", acc_c.size(), 3);
    check("b2b_n_rsp", n_rsp, 3);
    if (acc_c.size() == 3) begin
      check("b2b_gap1", acc_c[1] - acc_c[0], 3);
      check("b2b_gap2", acc_c[2] - acc_c[1], 3);
    end
    check("b2b_r1", model_regs[1], 3);

    // reset while in RESP drops rsp_valid asynchronously
    @(negedge clk);
    drive_cmd(4'd3, 2'd2, 2'd1, 2'd0, 1'b1, 8'hF0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("rstr_valid_before", rsp_valid, 1);
    rst = 1'b1;
    #1;
    check("rstr_valid_after", rsp_valid, 0);
    check("rstr_data", rsp_data, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // randomized commands
    for (int n = 0; n < 60; n++) begin
      run_op("rnd", 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
             int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_cmd_ctrl.md
# alu_cmd_ctrl

Command-driven controller that issues operations to the 8-bit ALU and collects its results. It accepts operation commands over a valid/ready handshake and reads operands from a 4-entry 8-bit register file. It drives the ALU's opcode and operand inputs, captures the ALU's result and overflow/negative/zero flags, writes the result back, and returns it on a valid/ready response channel. It sits between the command source (test harness or future sequencer) and the combinational ALU, which is instantiated alongside it.

## Interface
- REG_AW, 2, register-file address width; the file has 2**REG_AW entries of 8 bits.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  4  ALU opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL, 7 SHR, 8 SLT; 9–15 illegal.
- cmd_rd  in  REG_AW  destination register.
- cmd_rs1  in  REG_AW  source register for operand A.
- cmd_rs2  in  REG_AW  source register for operand B; used when cmd_imm_en=0.
- cmd_imm_en  in  1  when 1, operand B = cmd_imm.
- cmd_imm  in  8  immediate operand.
- alu_a, alu_b  out  8 each  ALU operands, registered.
- alu_opcode  out  4  ALU opcode, registered.
- alu_result  in  8  ALU result.
- alu_overflow, alu_negative, alu_zero  in  1 each  ALU flags.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  8  captured result.
- rsp_flags  out  3  {overflow, negative, zero}.
- rsp_err  out  1  command had an illegal opcode.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - cmd_ready = 1.
  - On cmd_valid, at the edge:
    - latch alu_opcode = cmd_op, rd = cmd_rd;
    - alu_a = reg[cmd_rs1];
    - alu_b = cmd_imm_en ? cmd_imm : reg[cmd_rs2];
    - go to EXEC.
- **EXEC**
  - ALU inputs are stable for the full cycle.
  - At the edge, for a legal opcode:
    - rsp_data = alu_result, rsp_flags = {alu_overflow, alu_negative, alu_zero}, rsp_err = 0;
    - reg[rd] = alu_result.
  - At the edge, for an illegal opcode:
    - rsp_data = 0, rsp_flags = 0, rsp_err = 1;
    - no register write.
  - Go to RESP.
- **RESP**
  - rsp_valid = 1; rsp_data, rsp_flags and rsp_err stay stable until accepted.
  - On rsp_ready, go to IDLE.
- cmd_ready = (state == IDLE) & ~rst; it is 0 in EXEC and RESP.
- Writeback completes before the next command can be accepted, so there are no read-after-write hazards and no bypass is needed.
- All arithmetic is performed by the ALU; the controller performs no arithmetic and no width extension.

## Timing
- Reset values:
  - state = IDLE; all registers = 0x00;
  - alu_a = alu_b = 0, alu_opcode = 0;
  - rsp_valid = 0, rsp_data = 0, rsp_flags = 0, rsp_err = 0;
  - cmd_ready = 0 while rst is high, 1 from the first cycle after release.
- Latency, with the command accepted at edge 0:
  - ALU inputs valid after edge 0;
  - result captured and written at edge 1;
  - rsp_valid high after edge 1.
- Maximum throughput is one command per 3 cycles, with rsp_ready held high.
- Backpressure: while rsp_valid=1 and rsp_ready=0, all response outputs are held and no command is accepted.
- Reset during EXEC or RESP:
  - immediate abort; rsp_valid drops asynchronously;
  - no writeback occurs; all registers clear.
- Simultaneous cmd_valid and rsp_ready in RESP: the command is not accepted that cycle (cmd_ready=0). It is accepted in the following IDLE cycle.
- rd == rs1 or rd == rs2 is legal: operands are read in IDLE and the write happens in EXEC.

## Structure
- Package alu_pkg holds:
  - opcode localparams OP_ADD..OP_SLT and OP_LAST = 4'd8;
  - FSM state encoding;
  - flag bit indices FLAG_V = 2, FLAG_N = 1, FLAG_Z = 0.
- Sub-module alu_cmd_regfile: 2**REG_AW × 8 registers, two asynchronous read ports, one synchronous write port, asynchronous clear.
- The ALU itself is external and is connected at the parent level.

## Test plan
- Load and overflow:
  - After reset, ADD r1 = r0 + imm 0x7F → rsp_data 0x7F, flags 000.
  - Then ADD r2 = r1 + imm 0x01 → 0x80, flags V=1, N=1, Z=0; r2 holds 0x80.
- Zero flag: SUB r3 = r2 − r2 → rsp_data 0x00, flags 001.
- SUB overflow: SUB r3 = r2 − imm 0x01 → 0x7F, flags V=1, N=0, Z=0.
- Illegal opcode: cmd_op 4'hA, rd = r1 → rsp_err 1, rsp_data 0x00; r1 still reads 0x7F on a following ADD r0 = r1 + imm 0.
- Backpressure: rsp_ready low for 5 cycles → rsp_valid, rsp_data and rsp_flags constant, cmd_ready 0 throughout; accepted on the 6th cycle.
- Reset mid-operation:
  - rst pulse while in EXEC of ADD r1 = r0 + imm 0x55 → rsp_valid 0 immediately.
  - After release, ADD r0 = r1 + imm 0 → 0x00, confirming no writeback and registers cleared.
- Back-to-back: cmd_valid and rsp_ready held high with ADD r1 += imm 1, three times → accepts exactly every 3 cycles, responses 0x01, 0x02, 0x03.
